tmul_nch: RTL and testbench

Multi-channel, parametrised temporal-unary stochastic multiplier for the SC unit library. Operand A, common to all channels, sets the stream length: A active cycles. Each channel's operand B is compared against a shared low-discrepancy sequence (Sobol dimension 1, i.e. the bit-reversed cycle index) to produce that channel's product bit-stream. The block also accumulates each stream into a binary result, in unipolar or bipolar mode, behind a start/busy/done handshake. It sits between the binary operand registers and downstream stream consumers or binary result capture.

---
 rtl/tmul_nch.sv | 113 +++++++++++
 tb/tb_tmul_nch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmul_nch.sv
// Multi-channel temporal-unary stochastic multiplier: A sets the stream length, each channel
// compares its B against a shared bit-reversed counter and accumulates the resulting stream.
module tmul_nch #(
    parameter int WIDTH   = 8,
    parameter int CH      = 4,
    parameter int BIPOLAR = 0,
    parameter int CW      = WIDTH + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                clr,
    input  logic [WIDTH-1:0]    iA,
    input  logic [CH*WIDTH-1:0] iB,
    output logic                busy,
    output logic                done,
    output logic                oV,
    output logic [CH-1:0]       oC,
    output logic [CH*CW-1:0]    oCnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    logic [1:0]          state_q, state_d;
    logic [WIDTH-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [CH*WIDTH-1:0] b_q, b_d;
    logic [CH*CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    rev;

    // Sobol dimension 1 is simply the bit-reversed cycle index.
    always_comb begin
        rev = '0;
        for (int k = 0; k < WIDTH; k++) begin
            rev[k] = idx_q[WIDTH-1-k];
        end
    end

    always_comb begin
        oC = '0;
        for (int i = 0; i < CH; i++) begin
            oC[i] = (state_q == S_RUN) && (b_q[i*WIDTH +: WIDTH] > rev);
        end
    end

    assign oV   = (state_q == S_RUN);
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign oCnt = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = iA;
                    b_d     = iB;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (iA != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                idx_d = idx_q + 1'b1;
                for (int i = 0; i < CH; i++) begin
                    if (BIPOLAR != 0) begin
                        cnt_d[i*CW +: CW] = oC[i] ? cnt_q[i*CW +: CW] + CNT_ONE
                                                  : cnt_q[i*CW +: CW] - CNT_ONE;
                    end else begin
                        cnt_d[i*CW +: CW] = cnt_q[i*CW +: CW] + (oC[i] ? CNT_ONE : CNT_ZERO);
                    end
                end
                if (idx_q == a_q - 1'b1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start in IDLE.
        if (clr) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tmul_nch.sv
// Directed bench for tmul_nch: a unipolar and a bipolar instance share the same stimulus,
// WIDTH=4 and CH=4, so every expected stream and count can be worked out by hand.
module tb_tmul_nch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        clr;
    logic [3:0]  iA;
    logic [15:0] iB;

    logic        busyU, doneU, oVU;
    logic [3:0]  oCU;
    logic [19:0] oCntU;
    logic        busyB, doneB, oVB;
    logic [3:0]  oCB;
    logic [19:0] oCntB;

    int errCount   = 0;
    int checkCount = 0;

    int          doneCyc;
    int          vCnt;
    int          leak;
    logic [15:0] sU [4];

    tmul_nch #(.WIDTH(4), .CH(4), .BIPOLAR(0)) dutU (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .iA(iA), .iB(iB),
        .busy(busyU), .done(doneU), .oV(oVU), .oC(oCU), .oCnt(oCntU)
    );

    tmul_nch #(.WIDTH(4), .CH(4), .BIPOLAR(1)) dutB (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .iA(iA), .iB(iB),
        .busy(busyB), .done(doneB), .oV(oVB), .oC(oCB), .oCnt(oCntB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cntU(input int i);
        logic [4:0] v;
        v = oCntU[i*5 +: 5];
        return int'(v);
    endfunction

    function automatic int cntB(input int i);
        logic [4:0] v;
        v = oCntB[i*5 +: 5];
        return int'($signed(v));
    endfunction

    // Leaves the bench at the falling edge of the first cycle after the accepting edge.
    task automatic applyStimulus(input logic [3:0] a, input logic [15:0] b);
        @(negedge clk);
        iA    = a;
        iB    = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int maxCyc, input int pulseCyc, input int clrCyc);
        doneCyc = -1;
        vCnt    = 0;
        leak    = 0;
        for (int ch = 0; ch < 4; ch++) sU[ch] = '0;
        for (int cyc = 1; cyc <= maxCyc; cyc++) begin
            if (oVU) begin
                vCnt++;
                for (int ch = 0; ch < 4; ch++) sU[ch] = {sU[ch][14:0], oCU[ch]};
            end else if (oCU != 4'd0) begin
                leak++;
            end
            if (doneU && doneCyc < 0) doneCyc = cyc;
            start = (cyc == pulseCyc);
            if (cyc == pulseCyc) begin
                iA = 4'd3;
                iB = 16'h0000;
            end
            clr = (cyc == clrCyc);
            if (cyc < maxCyc) @(negedge clk);
        end
        start = 1'b0;
        clr   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        iA    = '0;
        iB    = '0;
        #1;
        checkOutput("rst busy", busyU, 0);
        checkOutput("rst done", doneU, 0);
        checkOutput("rst oV", oVU, 0);
        checkOutput("rst oC", oCU, 0);
        checkOutput("rst oCnt", oCntU, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Unipolar reference run: B = {0,8,15,4} for channels 0..3.
        applyStimulus(4'd8, {4'd4, 4'd15, 4'd8, 4'd0});
        collect(11, 0, 0);
        checkOutput("uni doneCyc", doneCyc, 9);
        checkOutput("uni vCnt", vCnt, 8);
        checkOutput("uni leak", leak, 0);
        checkOutput("uni s0", sU[0], 16'h0000);
        checkOutput("uni s1", sU[1], 16'b10101010);
        checkOutput("uni s2", sU[2], 16'b11111111);
        checkOutput("uni s3", sU[3], 16'b10001000);
        checkOutput("uni cnt0", cntU(0), 0);
        checkOutput("uni cnt1", cntU(1), 4);
        checkOutput("uni cnt2", cntU(2), 8);
        checkOutput("uni cnt3", cntU(3), 2);
        checkOutput("uni bip0", cntB(0), -8);
        checkOutput("uni bip1", cntB(1), 0);
        checkOutput("uni bip2", cntB(2), 8);
        checkOutput("uni bip3", cntB(3), -4);
        checkOutput("uni idle busy", busyU, 0);

        // Bipolar reference run: B = {12,8,0,15}.
        applyStimulus(4'd8, {4'd15, 4'd0, 4'd8, 4'd12});
        collect(11, 0, 0);
        checkOutput("bip doneCyc", doneCyc, 9);
        checkOutput("bip cnt0", cntB(0), 4);
        checkOutput("bip cnt1", cntB(1), 0);
        checkOutput("bip cnt2", cntB(2), -8);
        checkOutput("bip cnt3", cntB(3), 8);
        checkOutput("bip uni0", cntU(0), 6);
        checkOutput("bip uni3", cntU(3), 8);

        // A=0 goes straight to DONE and clears the previous results.
        applyStimulus(4'd0, 16'hFFFF);
        collect(3, 0, 0);
        checkOutput("a0 doneCyc", doneCyc, 1);
        checkOutput("a0 vCnt", vCnt, 0);
        checkOutput("a0 cnt3", cntU(3), 0);
        checkOutput("a0 bip3", cntB(3), 0);
        checkOutput("a0 busy", busyU, 0);

        // A=15, B=15: r covers 0..14 only, so every cycle yields a one.
        applyStimulus(4'd15, 16'hFFFF);
        collect(18, 0, 0);
        checkOutput("a15 doneCyc", doneCyc, 16);
        checkOutput("a15 vCnt", vCnt, 15);
        checkOutput("a15 cnt0", cntU(0), 15);
        checkOutput("a15 bip0", cntB(0), 15);

        // start pulsed mid-run must neither disturb nor queue a run.
        applyStimulus(4'd8, {4'd4, 4'd15, 4'd8, 4'd0});
        collect(12, 3, 0);
        checkOutput("ign doneCyc", doneCyc, 9);
        checkOutput("ign vCnt", vCnt, 8);
        checkOutput("ign s1", sU[1], 16'b10101010);
        checkOutput("ign cnt3", cntU(3), 2);
        checkOutput("ign busy", busyU, 0);

        // clr during RUN cycle 3 aborts without a done pulse.
        applyStimulus(4'd8, {4'd4, 4'd15, 4'd8, 4'd0});
        collect(8, 0, 3);
        checkOutput("clr doneCyc", doneCyc, -1);
        checkOutput("clr vCnt", vCnt, 3);
        checkOutput("clr busy", busyU, 0);
        checkOutput("clr cnt2", cntU(2), 0);
        checkOutput("clr bip2", cntB(2), 0);

        // clr beats start in IDLE.
        @(negedge clk);
        iA    = 4'd5;
        iB    = 16'hFFFF;
        start = 1'b1;
        clr   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clr   = 1'b0;
        checkOutput("clrstart busy", busyU, 0);
        collect(4, 0, 0);
        checkOutput("clrstart doneCyc", doneCyc, -1);
        checkOutput("clrstart vCnt", vCnt, 0);

        // Back-to-back: start held through DONE is taken only in the following IDLE cycle.
        applyStimulus(4'd8, {4'd4, 4'd15, 4'd8, 4'd0});
        collect(9, 0, 0);
        checkOutput("b2b first done", doneCyc, 9);
        iA    = 4'd4;
        iB    = {4'd0, 4'd13, 4'd9, 4'd3};
        start = 1'b1;
        @(negedge clk);
        checkOutput("b2b idle busy", busyU, 0);
        checkOutput("b2b idle cnt1", cntU(1), 4);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b accept busy", busyU, 1);
        checkOutput("b2b cleared", oCntU, 0);
        collect(7, 0, 0);
        checkOutput("b2b doneCyc", doneCyc, 5);
        checkOutput("b2b s0", sU[0], 16'b1000);
        checkOutput("b2b s1", sU[1], 16'b1110);
        checkOutput("b2b cnt1", cntU(1), 3);
        checkOutput("b2b cnt2", cntU(2), 4);
        checkOutput("b2b bip0", cntB(0), -2);
        checkOutput("b2b bip3", cntB(3), -4);

        // Asynchronous reset in the middle of a run.
        applyStimulus(4'd8, {4'd4, 4'd15, 4'd8, 4'd0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst busy", busyU, 0);
        checkOutput("midrst oV", oVU, 0);
        checkOutput("midrst oC", oCU, 0);
        checkOutput("midrst oCnt", oCntU, 0);
        @(negedge clk);
        collect(4, 0, 0);
        checkOutput("midrst doneCyc", doneCyc, -1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst after busy", busyU, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
